booth_mult_ctrl: RTL and testbench
==================================

// Module: booth_mult_ctrl
// PURPOSE
//   Sequencing FSM for the 16-bit Booth (radix-2) multiplier datapath (multiplierbinary).
//   Drives the datapath control strobes (clrA/ldA/ldQ/ldM/clrQ/clrff/sftA/sftQ/addsub/decr/ldcnt).
//   Consumes datapath status (q0, qm1, eqz).
//   Upstream presents the two operands in turn on the shared data_in bus; this block
//   sequences them and reports completion.
// PARAMETERS
//   WIDTH   16  operand width; also the value the datapath counter is loaded with on ldcnt
// PORTS
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  request a multiply; sampled only in IDLE
//   q0       in   1  datapath Q[0]
//   qm1      in   1  datapath Q[-1] flip-flop
//   eqz      in   1  datapath iteration counter == 0 (registered in datapath)
//   busy     out  1  high in every state except IDLE
//   opnd_sel out  1  0: upstream must drive multiplier on data_in; 1: drive multiplicand
//   done     out  1  one-cycle pulse; product valid in {A,Q}
//   clrA,clrQ,clrff,ldA,ldQ,ldM,sftA,sftQ,addsub,decr,ldcnt  out  1 each  datapath strobes
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; every output 0 (opnd_sel=0, addsub=0).
//   All outputs are Moore (decoded from registered state). Only CHECK next-state uses q0/qm1/eqz.
//   addsub encoding: 1 = A<=A+M, 0 = A<=A-M; addsub is meaningful only while ldA=1, else 0.
//   States and outputs:
//     IDLE   : all 0. start=1 -> LOADQ, else stay.
//     LOADQ  : clrA=1, clrff=1, ldQ=1, ldcnt=1, opnd_sel=0 -> LOADM.
//     LOADM  : ldM=1, opnd_sel=1 -> CHECK.
//     CHECK  : no strobes. Priority: eqz=1 -> DONE; else {q0,qm1}=10 -> SUB;
//              01 -> ADD; 00/11 -> SHIFT.
//     ADD    : ldA=1, addsub=1 -> SHIFT.
//     SUB    : ldA=1, addsub=0 -> SHIFT.
//     SHIFT  : sftA=1, sftQ=1, decr=1 (arithmetic right shift of {A,Q,qm1}) -> CHECK.
//     DONE   : done=1 -> IDLE unconditionally.
//   Latency: start sampled at edge E0.
//     done is high in the cycle following edge E(2*WIDTH + n_ops + 3).
//     n_ops = number of ADD/SUB visits.
//   Exactly WIDTH SHIFT visits per operation.
//   The first CHECK sees eqz=0, because the counter was loaded with WIDTH.
//   start while busy=1: ignored, not queued.
//   start held high through DONE: re-accepted in IDLE on the cycle after done.
//     Minimum spacing is 1 idle cycle.
//   Reset mid-operation: immediate return to IDLE with all outputs 0.
//     The datapath contents are then undefined to the caller.
//   Never assert ldA together with sftA, or ldQ together with sftQ (mutually exclusive by state).
//   eqz stuck at 0 (datapath fault): the FSM keeps iterating. There is no watchdog in this block.
// STRUCTURE
//   Package booth_ctrl_pkg:
//     state encoding localparams (IDLE..DONE, 3-bit);
//     ADDSUB_ADD=1'b1, ADDSUB_SUB=1'b0;
//     BOOTH_NOP/ADD/SUB step codes.
//   Sub-module booth_step_decode (combinational):
//     {q0,qm1} -> step code {NOP,ADD,SUB}.
//     Instantiated once in CHECK next-state logic.
//   Top: state register (async clear) + next-state case + output decode case.
// TESTING (bench pairs this block with multiplierbinary, WIDTH=16)
//   1. rst_n=0 mid-run, any state -> all outputs 0 within the same cycle; busy=0.
//      After release: IDLE, idle until start.
//   2. Multiplier 3, multiplicand 5 -> sequence LOADQ,LOADM, then SUB, SHIFT, SHIFT, ADD, ...
//      n_ops=2; done after edge E37; {A,Q}=32'd15.
//   3. Multiplier -4 (0xFFFC), multiplicand 7 -> n_ops=1; done after edge E36;
//      {A,Q}=32'hFFFF_FFE4 (-28).
//   4. Multiplier 0x5555, multiplicand 1 -> n_ops=16, alternating SUB/ADD; done after edge E51;
//      {A,Q}=32'h0000_5555.
//   5. start pulsed during SHIFT of a running op -> ignored; exactly one done pulse; result unchanged.
//   6. start held high for 3 operations -> done pulses separated by exactly 1 IDLE cycle.
//      opnd_sel sequence is 0,1 per operation.

Source files
------------

// File: rtl/booth_ctrl_pkg.sv
// rtl/booth_ctrl_pkg.sv - shared encodings for the radix-2 Booth multiplier sequencer
//
// Contents:
//   booth_state_e           3-bit FSM state encoding (IDLE..DONE)
//   ADDSUB_ADD/ADDSUB_SUB   polarity of the datapath addsub strobe
//   BOOTH_NOP/ADD/SUB       step codes produced from {q0, qm1}
package booth_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADQ = 3'd1,
        S_LOADM = 3'd2,
        S_CHECK = 3'd3,
        S_ADD   = 3'd4,
        S_SUB   = 3'd5,
        S_SHIFT = 3'd6,
        S_DONE  = 3'd7
    } booth_state_e;

    // addsub = 1 selects A <= A + M, 0 selects A <= A - M
    localparam logic ADDSUB_ADD = 1'b1;
    localparam logic ADDSUB_SUB = 1'b0;

    localparam logic [1:0] BOOTH_NOP = 2'd0;
    localparam logic [1:0] BOOTH_ADD = 2'd1;
    localparam logic [1:0] BOOTH_SUB = 2'd2;

endpackage

// File: rtl/booth_step_decode.sv
// rtl/booth_step_decode.sv - radix-2 Booth recoding of {q0, qm1} into a step code
//
// Ports:
//   q0    in   1  current multiplier LSB (datapath Q[0])
//   qm1   in   1  previously shifted-out bit (datapath Q[-1])
//   step  out  2  BOOTH_NOP / BOOTH_ADD / BOOTH_SUB
module booth_step_decode
    import booth_ctrl_pkg::*;
(
    input  logic       q0,
    input  logic       qm1,
    output logic [1:0] step
);

    // 10: start of a run of ones -> subtract M
    // 01: end of a run of ones   -> add M
    // 00 / 11: inside a run      -> shift only
    always_comb begin
        step = BOOTH_NOP;
        if (q0 && !qm1) begin
            step = BOOTH_SUB;
        end else if (!q0 && qm1) begin
            step = BOOTH_ADD;
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - sequencing FSM for the 16-bit radix-2 Booth multiplier datapath
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 multiply request, sampled only in IDLE
//   q0, qm1, eqz          datapath status: Q[0], Q[-1], iteration counter == 0
//   busy                  high in every state except IDLE
//   opnd_sel              0: upstream drives multiplier on data_in, 1: multiplicand
//   done                  one-cycle pulse, product valid in {A,Q}
//   clrA, clrQ, clrff, ldA, ldQ, ldM, sftA, sftQ, addsub, decr, ldcnt
//                         datapath control strobes (Moore, decoded from state)
module booth_mult_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
    output logic busy,
    output logic opnd_sel,
    output logic done,
    output logic clrA,
    output logic clrQ,
    output logic clrff,
    output logic ldA,
    output logic ldQ,
    output logic ldM,
    output logic sftA,
    output logic sftQ,
    output logic addsub,
    output logic decr,
    output logic ldcnt
);

    // WIDTH only sets the datapath counter reload value; the FSM itself is
    // width-independent, so the parameter is just sanity-checked here.
    if (WIDTH < 1) begin : g_width_check
        $error("booth_mult_ctrl: WIDTH must be at least 1");
    end

    booth_state_e state_q;
    booth_state_e state_d;
    logic [1:0]   step;

    booth_step_decode u_step_decode (
        .q0   (q0),
        .qm1  (qm1),
        .step (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOADQ;
            S_LOADQ: state_d = S_LOADM;
            S_LOADM: state_d = S_CHECK;
            // eqz wins over the recoded step: after the last shift no
            // further add/subtract may touch A.
            S_CHECK: begin
                if (eqz) begin
                    state_d = S_DONE;
                end else if (step == BOOTH_SUB) begin
                    state_d = S_SUB;
                end else if (step == BOOTH_ADD) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        opnd_sel = 1'b0;
        done     = 1'b0;
        clrA     = 1'b0;
        clrQ     = 1'b0;
        clrff    = 1'b0;
        ldA      = 1'b0;
        ldQ      = 1'b0;
        ldM      = 1'b0;
        sftA     = 1'b0;
        sftQ     = 1'b0;
        addsub   = 1'b0;
        decr     = 1'b0;
        ldcnt    = 1'b0;
        case (state_q)
            S_LOADQ: begin
                clrA  = 1'b1;
                clrff = 1'b1;
                ldQ   = 1'b1;
                ldcnt = 1'b1;
            end
            S_LOADM: begin
                ldM      = 1'b1;
                opnd_sel = 1'b1;
            end
            S_ADD: begin
                ldA    = 1'b1;
                addsub = ADDSUB_ADD;
            end
            S_SUB: begin
                ldA    = 1'b1;
                addsub = ADDSUB_SUB;
            end
            S_SHIFT: begin
                sftA = 1'b1;
                sftQ = 1'b1;
                decr = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - self-checking bench for booth_mult_ctrl with a behavioural datapath
module tb_booth_mult_ctrl;

    localparam int WIDTH    = 16;
    localparam int LAT_BASE = 2 * WIDTH + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] mplier = 16'd0;
    logic [15:0] mcand = 16'd0;

    logic busy, opnd_sel, done;
    logic clrA, clrQ, clrff, ldA, ldQ, ldM, sftA, sftQ, addsub, decr, ldcnt;
    logic q0, qm1, eqz;

    // behavioural stand-in for the multiplier datapath
    logic [15:0] dp_a = 16'd0;
    logic [15:0] dp_q = 16'd0;
    logic [15:0] dp_m = 16'd0;
    logic        dp_qm1 = 1'b0;
    logic [4:0]  dp_cnt = 5'd0;
    logic [15:0] data_in;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // high-level expectation model
    bit              m_busy = 1'b0;
    int              m_c0 = 0;
    int              m_end = 0;
    int              m_n = 0;
    logic [31:0]     m_prod = 32'd0;
    int              sh_cnt = 0;
    int              op_cnt = 0;

    always #5 clk = ~clk;

    booth_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .q0       (q0),
        .qm1      (qm1),
        .eqz      (eqz),
        .busy     (busy),
        .opnd_sel (opnd_sel),
        .done     (done),
        .clrA     (clrA),
        .clrQ     (clrQ),
        .clrff    (clrff),
        .ldA      (ldA),
        .ldQ      (ldQ),
        .ldM      (ldM),
        .sftA     (sftA),
        .sftQ     (sftQ),
        .addsub   (addsub),
        .decr     (decr),
        .ldcnt    (ldcnt)
    );

    assign data_in = opnd_sel ? mcand : mplier;
    assign q0      = dp_q[0];
    assign qm1     = dp_qm1;
    assign eqz     = (dp_cnt == 5'd0);

    always @(posedge clk) begin
        if (clrA)       dp_a <= 16'd0;
        else if (ldA)   dp_a <= addsub ? dp_a + dp_m : dp_a - dp_m;
        else if (sftA)  dp_a <= {dp_a[15], dp_a[15:1]};
        if (ldQ)        dp_q <= data_in;
        else if (sftQ)  dp_q <= {dp_a[0], dp_q[15:1]};
        if (clrff)      dp_qm1 <= 1'b0;
        else if (sftQ)  dp_qm1 <= dp_q[0];
        if (ldM)        dp_m <= data_in;
        if (ldcnt)      dp_cnt <= 5'(WIDTH);
        else if (decr)  dp_cnt <= dp_cnt - 5'd1;
    end

    // number of add/subtract steps = number of bit transitions in {x, 1'b0}
    function automatic int booth_ops(input logic [15:0] x);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (x[i] != prev) n++;
            prev = x[i];
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_end) m_busy = 1'b0;
        end else if (start) begin
            m_busy = 1'b1;
            m_c0   = cyc + 1;
            m_n    = booth_ops(mplier);
            m_end  = m_c0 + LAT_BASE + m_n;
            m_prod = 32'($signed(mplier) * $signed(mcand));
            sh_cnt = 0;
            op_cnt = 0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit e_done, e_load, e_opm;
        if (!rst_n) begin
            chk("reset_outputs",
                32'({busy, opnd_sel, done, clrA, clrQ, clrff, ldA, ldQ, ldM, sftA, sftQ, addsub, decr, ldcnt}),
                32'd0);
        end else begin
            e_done = m_busy && (cyc == m_end);
            e_load = m_busy && (cyc == m_c0);
            e_opm  = m_busy && (cyc == m_c0 + 1);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("opnd_sel", 32'(opnd_sel), 32'(e_opm));
            chk("load_q_strobes", 32'({clrA, clrff, ldQ, ldcnt}), 32'({4{e_load}}));
            chk("ldM", 32'(ldM), 32'(e_opm));
            chk("exclusive", 32'({ldA & sftA, ldQ & sftQ, addsub & ~ldA, clrQ}), 32'd0);
            chk("shift_group", 32'({sftQ, decr}), 32'({2{sftA}}));
            if (!m_busy) chk("idle_strobes", 32'({ldA, sftA, ldM, ldQ}), 32'd0);
            if (sftA) sh_cnt++;
            if (ldA)  op_cnt++;
            if (e_done) begin
                chk("product", {dp_a, dp_q}, m_prod);
                chk("shift_count", 32'(sh_cnt), 32'(WIDTH));
                chk("op_count", 32'(op_cnt), 32'(m_n));
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                          input logic [31:0] exp_prod, input int exp_first_ld,
                          input logic exp_first_as, input bit poke);
        int s, lat, n_done, first_ld;
        logic first_as;
        logic [31:0] prod;
        bit poked;
        lat = -1; n_done = 0; first_ld = -1; first_as = 1'bx; prod = 32'hx; poked = 1'b0;
        @(negedge clk);
        mplier = a;
        mcand  = b;
        start  = 1'b1;
        s      = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (done) begin
                if (lat < 0) begin
                    lat  = cyc - s;
                    prod = {dp_a, dp_q};
                end
                n_done++;
            end
            if (ldA && first_ld < 0) begin
                first_ld = cyc - s;
                first_as = addsub;
            end
            if (poke && sftA && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("done_pulses", 32'(n_done), 32'd1);
        chk("product_literal", prod, exp_prod);
        chk("first_ldA_cycle", 32'(first_ld), 32'(exp_first_ld));
        chk("first_addsub", 32'(first_as), 32'(exp_first_as));
    endtask

    initial begin
        int s, nd, idle_gap;
        int d[3];
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // 3 x 5: SUB first, then ADD; 2 ops
        run_op(16'd3, 16'd5, 37, 32'd15, 3, 1'b0, 1'b0);
        // -4 x 7: single SUB at third CHECK
        run_op(16'hFFFC, 16'd7, 36, 32'hFFFF_FFE4, 7, 1'b0, 1'b0);
        // 0x5555 x 1: op on every iteration
        run_op(16'h5555, 16'd1, 51, 32'h0000_5555, 3, 1'b0, 1'b0);
        // start poked during SHIFT must be ignored
        run_op(16'd3, 16'd5, 37, 32'd15, 3, 1'b0, 1'b1);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        mplier = 16'd3; mcand = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({busy, opnd_sel, done, clrA, clrQ, clrff, ldA, ldQ, ldM, sftA, sftQ, addsub, decr, ldcnt}),
            32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_midrun_reset", 32'(busy), 32'd0);

        // start held high across three back-to-back operations
        @(negedge clk);
        mplier = 16'd3; mcand = 16'd5; start = 1'b1;
        s = cyc + 1;
        nd = 0; idle_gap = 0;
        d[0] = -1; d[1] = -1; d[2] = -1;
        for (int i = 0; i < 200 && nd < 3; i++) begin
            @(negedge clk);
            if (nd > 0 && !busy) idle_gap++;
            if (done) begin
                d[nd] = cyc;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(nd), 32'd3);
        chk("held_first_latency", 32'(d[0] - s), 32'd37);
        chk("held_spacing_1", 32'(d[1] - d[0]), 32'd39);
        chk("held_spacing_2", 32'(d[2] - d[1]), 32'd39);
        chk("held_idle_cycles", 32'(idle_gap), 32'd2);
        repeat (5) @(negedge clk);
        chk("idle_at_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
